// File: rtl/wb_ic_pkg.sv
// Shared types and constants for the krake Wishbone interconnect (wb_interconnect).
package wb_ic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Read data returned on decode errors and timeouts; sliced to DW by users.
  localparam logic [63:0] DEAD_DATA = '1;

  // Layout of the fault register byte.
  localparam int FAULT_TO_BIT  = 7;
  localparam int FAULT_DEC_BIT = 6;
  localparam int FAULT_SEL_LSB = 0;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_ic_fault_log.sv
// Sticky fault flags and last faulting select for wb_interconnect.
// Only instantiated when WB_FAULT_LOG_EN is defined.
module wb_ic_fault_log
  import wb_ic_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       log_timeout,
  input  logic       log_decode,
  input  logic       clear,
  input  logic [3:0] fault_sel,
  output logic [7:0] rdata
);

  logic       to_sticky;
  logic       dec_sticky;
  logic [3:0] last_sel;

  // A write clears everything; otherwise each fault event sets its flag and records the select.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_sticky  <= 1'b0;
      dec_sticky <= 1'b0;
      last_sel   <= '0;
    end else if (clear) begin
      to_sticky  <= 1'b0;
      dec_sticky <= 1'b0;
      last_sel   <= '0;
    end else begin
      if (log_timeout) to_sticky <= 1'b1;
      if (log_decode) dec_sticky <= 1'b1;
      if (log_timeout || log_decode) last_sel <= fault_sel;
    end
  end

  always_comb begin
    rdata                      = '0;
    rdata[FAULT_TO_BIT]        = to_sticky;
    rdata[FAULT_DEC_BIT]       = dec_sticky;
    rdata[FAULT_SEL_LSB +: 4]  = last_sel;
  end

endmodule

// File: rtl/wb_interconnect.sv
// Registered single-master, N-slave Wishbone router with per-transaction watchdog.
// Optional internal fault register at select FAULT_SEL, enabled by macro WB_FAULT_LOG_EN.
module wb_interconnect
  import wb_ic_pkg::*;
#(
  parameter int               NUM_SLAVES = 12,
  parameter int               DW         = 8,
  parameter int               AW         = 8,
  parameter int               SEL_W      = 4,
  parameter int               TIMEOUT    = 15,
  parameter logic [SEL_W-1:0] FAULT_SEL  = SEL_W'(15)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     m_stb_i,
  input  logic                     m_we_i,
  input  logic [AW-1:0]            m_adr_i,
  input  logic [DW-1:0]            m_dat_i,
  output logic [DW-1:0]            m_dat_o,
  output logic                     m_ack_o,
  output logic                     m_err_o,
  output logic [NUM_SLAVES-1:0]    s_stb_o,
  output logic                     s_we_o,
  output logic [AW-SEL_W-1:0]      s_adr_o,
  output logic [DW-1:0]            s_dat_o,
  input  logic [NUM_SLAVES*DW-1:0] s_dat_i,
  input  logic [NUM_SLAVES-1:0]    s_ack_i
);

  localparam int CW = cnt_width(TIMEOUT);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] m_sel;
  logic [SEL_W-1:0] sel_q;
  logic [CW-1:0]    cnt;
  logic             err_q;
  logic             req_valid;
  logic             req_fault;
  logic             ack_hit;
  logic             timeout_hit;
  logic [DW-1:0]    ack_data;
  logic [7:0]       fault_rdata;

  assign m_sel = m_adr_i[AW-1:AW-SEL_W];

`ifdef WB_FAULT_LOG_EN
  localparam bit FAULT_LOG_EN = 1'b1;

  logic       log_timeout;
  logic       log_decode;
  logic       log_clear;
  logic [3:0] log_sel;

  assign log_timeout = (state == BUSY) && !ack_hit && timeout_hit;
  assign log_decode  = (state == IDLE) && m_stb_i && !req_fault && !req_valid;
  assign log_clear   = (state == IDLE) && m_stb_i && req_fault && m_we_i;
  assign log_sel     = (state == BUSY) ? 4'(sel_q) : 4'(m_sel);

  wb_ic_fault_log u_fault_log (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .log_timeout (log_timeout),
    .log_decode  (log_decode),
    .clear       (log_clear),
    .fault_sel   (log_sel),
    .rdata       (fault_rdata)
  );
`else
  localparam bit FAULT_LOG_EN = 1'b0;

  assign fault_rdata = '0;
`endif

  // Request decode and response detection; s_stb_o is one-hot, so masking acks with it
  // ignores acks from slaves that are not being addressed.
  always_comb begin
    req_fault   = FAULT_LOG_EN && (m_sel == FAULT_SEL);
    req_valid   = int'(m_sel) < NUM_SLAVES;
    ack_hit     = |(s_ack_i & s_stb_o);
    timeout_hit = (cnt == CW'(TIMEOUT - 1));
    ack_data    = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (s_stb_o[k]) ack_data |= s_dat_i[k*DW +: DW];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m_stb_i) state_nxt = (req_valid && !req_fault) ? BUSY : RESP;
      end
      BUSY: begin
        if (ack_hit || timeout_hit) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_stb_o = '0;
    m_ack_o = 1'b0;
    m_err_o = 1'b0;
    case (state)
      BUSY: begin
        for (int k = 0; k < NUM_SLAVES; k++) s_stb_o[k] = (sel_q == SEL_W'(k));
      end
      RESP: begin
        m_ack_o = !err_q;
        m_err_o = err_q;
      end
      default: ;
    endcase
  end

  // Request latching, watchdog counter and response data; ack wins over a same-cycle timeout.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sel_q   <= '0;
      cnt     <= '0;
      err_q   <= 1'b0;
      m_dat_o <= '0;
      s_we_o  <= 1'b0;
      s_adr_o <= '0;
      s_dat_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (m_stb_i) begin
            sel_q   <= m_sel;
            cnt     <= '0;
            s_we_o  <= m_we_i;
            s_adr_o <= m_adr_i[AW-SEL_W-1:0];
            s_dat_o <= m_dat_i;
            if (req_fault) begin
              err_q   <= 1'b0;
              m_dat_o <= DW'(fault_rdata);
            end else if (!req_valid) begin
              err_q   <= 1'b1;
              m_dat_o <= DEAD_DATA[DW-1:0];
            end else begin
              err_q   <= 1'b0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (ack_hit) begin
            err_q   <= 1'b0;
            m_dat_o <= ack_data;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            m_dat_o <= DEAD_DATA[DW-1:0];
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_interconnect.sv
// Self-checking bench for wb_interconnect with randomized transactions against a
// transaction-level reference model; fault-register checks follow WB_FAULT_LOG_EN.
module tb_wb_interconnect;

  localparam int NS = 12;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int SEL_W = 4;
  localparam int TO = 15;
  localparam int NEVER = 99;

`ifdef WB_FAULT_LOG_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 m_stb_i;
  logic                 m_we_i;
  logic [AW-1:0]        m_adr_i;
  logic [DW-1:0]        m_dat_i;
  logic [DW-1:0]        m_dat_o;
  logic                 m_ack_o;
  logic                 m_err_o;
  logic [NS-1:0]        s_stb_o;
  logic                 s_we_o;
  logic [AW-SEL_W-1:0]  s_adr_o;
  logic [DW-1:0]        s_dat_o;
  logic [NS*DW-1:0]     s_dat_i;
  logic [NS-1:0]        s_ack_i;

  int          checks = 0;
  int          errors = 0;
  int          ack_delay[NS];
  logic [7:0]  slave_data[NS];
  int          stb_cnt[NS];
  logic [NS-1:0] noise_mask;
  bit          chain_pending = 1'b0;
  bit          fm_to = 1'b0;
  bit          fm_dec = 1'b0;
  logic [3:0]  fm_last = '0;
  logic [7:0]  r_adr;
  logic [7:0]  r_dat;

  wb_interconnect dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i)
  );

  always #5 clk = ~clk;

  // Slave models: each acks once its strobe has been high for ack_delay cycles;
  // unselected slaves may assert spurious acks from noise_mask.
  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) stb_cnt[k] <= s_stb_o[k] ? stb_cnt[k] + 1 : 0;
  end

  always_comb begin
    for (int k = 0; k < NS; k++) begin
      s_ack_i[k] = s_stb_o[k] ? (stb_cnt[k] == ack_delay[k]) : noise_mask[k];
      s_dat_i[k*DW +: DW] = slave_data[k];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // One master transaction; hold=1 keeps m_stb_i high through RESP so the next call chains.
  task automatic applyStimulus(input logic we, input logic [7:0] adr, input logic [7:0] dat, input bit hold);
    logic [3:0]    sel;
    logic [NS-1:0] exp_onehot;
    logic [7:0]    exp_data;
    bit            exp_err;
    bit            done;
    int            d, lat, exp_lat, stb_cycles, exp_stb, stb_bad;
    sel        = adr[7:4];
    exp_onehot = '0;
    if (FAULT_EN && sel == 4'hF) begin
      exp_err  = 1'b0;
      exp_lat  = 1;
      exp_stb  = 0;
      exp_data = {fm_to, fm_dec, 2'b00, fm_last};
      if (we) begin
        fm_to   = 1'b0;
        fm_dec  = 1'b0;
        fm_last = '0;
      end
    end else if (int'(sel) >= NS) begin
      exp_err  = 1'b1;
      exp_lat  = 1;
      exp_stb  = 0;
      exp_data = 8'hFF;
      fm_dec   = 1'b1;
      fm_last  = sel;
    end else begin
      d = ack_delay[int'(sel)];
      exp_onehot[sel] = 1'b1;
      if (d < TO) begin
        exp_err  = 1'b0;
        exp_lat  = d + 2;
        exp_stb  = d + 1;
        exp_data = slave_data[int'(sel)];
      end else begin
        exp_err  = 1'b1;
        exp_lat  = TO + 1;
        exp_stb  = TO;
        exp_data = 8'hFF;
        fm_to    = 1'b1;
        fm_last  = sel;
      end
    end
    if (chain_pending) exp_lat++;
    else @(negedge clk);
    chain_pending = 1'b0;
    m_stb_i = 1'b1;
    m_we_i  = we;
    m_adr_i = adr;
    m_dat_i = dat;
    lat = 0;
    stb_cycles = 0;
    stb_bad = 0;
    done = 1'b0;
    while (!done && lat < TO + 8) begin
      @(negedge clk);
      lat++;
      if (s_stb_o != '0) begin
        stb_cycles++;
        if (s_stb_o != exp_onehot) stb_bad++;
      end
      if (m_ack_o || m_err_o) done = 1'b1;
    end
    checkOutput("resp_seen", 32'(done), 32'd1);
    checkOutput("latency", 32'(lat), 32'(exp_lat));
    checkOutput("ack", 32'(m_ack_o), 32'(!exp_err));
    checkOutput("err", 32'(m_err_o), 32'(exp_err));
    checkOutput("rdata", 32'(m_dat_o), 32'(exp_data));
    checkOutput("stb_cycles", 32'(stb_cycles), 32'(exp_stb));
    checkOutput("stb_onehot", 32'(stb_bad), 32'd0);
    checkOutput("s_we", 32'(s_we_o), 32'(we));
    checkOutput("s_adr", 32'(s_adr_o), 32'(adr[3:0]));
    checkOutput("s_dat", 32'(s_dat_o), 32'(dat));
    if (hold) begin
      chain_pending = 1'b1;
    end else begin
      m_stb_i = 1'b0;
      @(negedge clk);
      checkOutput("pulse_end", 32'({m_ack_o, m_err_o}), 32'd0);
      checkOutput("rdata_hold", 32'(m_dat_o), 32'(exp_data));
    end
  endtask

  initial begin
    rst = 1'b1;
    m_stb_i = 1'b0;
    m_we_i = 1'b0;
    m_adr_i = '0;
    m_dat_i = '0;
    noise_mask = '0;
    for (int k = 0; k < NS; k++) begin
      ack_delay[k] = NEVER;
      slave_data[k] = 8'(k * 17 + 3);
    end
    repeat (2) @(negedge clk);
    checkOutput("rst_ack", 32'(m_ack_o), 32'd0);
    checkOutput("rst_err", 32'(m_err_o), 32'd0);
    checkOutput("rst_mdat", 32'(m_dat_o), 32'd0);
    checkOutput("rst_stb", 32'(s_stb_o), 32'd0);
    checkOutput("rst_swe", 32'(s_we_o), 32'd0);
    checkOutput("rst_sadr", 32'(s_adr_o), 32'd0);
    checkOutput("rst_sdat", 32'(s_dat_o), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed write to slave 3");
    ack_delay[3] = 1;
    applyStimulus(1'b1, 8'h32, 8'hA5, 1'b0);

    $display("[TB] directed read from slave 11 with spurious ack on slave 2");
    ack_delay[11] = 4;
    slave_data[11] = 8'h5C;
    noise_mask = 12'h004;
    applyStimulus(1'b0, 8'hB0, 8'h00, 1'b0);
    noise_mask = '0;

    $display("[TB] directed timeout on slave 4");
    ack_delay[4] = NEVER;
    applyStimulus(1'b0, 8'h40, 8'h00, 1'b0);

    $display("[TB] decode error and fault register");
    if (FAULT_EN) applyStimulus(1'b1, 8'hF0, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'hD0, 8'h00, 1'b0);
    if (FAULT_EN) begin
      applyStimulus(1'b0, 8'hF0, 8'h00, 1'b0);
      applyStimulus(1'b1, 8'hF0, 8'h00, 1'b0);
      applyStimulus(1'b0, 8'hF0, 8'h00, 1'b0);
    end

    $display("[TB] reset during BUSY");
    ack_delay[5] = NEVER;
    @(negedge clk);
    m_stb_i = 1'b1;
    m_we_i = 1'b1;
    m_adr_i = 8'h57;
    m_dat_i = 8'h3C;
    repeat (3) @(negedge clk);
    checkOutput("busy_stb", 32'(s_stb_o), 32'h020);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_stb", 32'(s_stb_o), 32'd0);
    checkOutput("async_resp", 32'({m_ack_o, m_err_o}), 32'd0);
    checkOutput("async_sadr", 32'(s_adr_o), 32'd0);
    m_stb_i = 1'b0;
    fm_to = 1'b0;
    fm_dec = 1'b0;
    fm_last = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_resp", 32'({m_ack_o, m_err_o}), 32'd0);
    checkOutput("post_rst_stb", 32'(s_stb_o), 32'd0);
    ack_delay[5] = 2;
    applyStimulus(1'b0, 8'h51, 8'h00, 1'b0);

    $display("[TB] ack on the timeout cycle, then back-to-back");
    ack_delay[0] = TO - 1;
    slave_data[0] = 8'h9E;
    applyStimulus(1'b0, 8'h07, 8'h00, 1'b1);
    ack_delay[3] = 0;
    applyStimulus(1'b1, 8'h35, 8'h61, 1'b0);

    $display("[TB] randomized transactions");
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < NS; k++) begin
        ack_delay[k] = $urandom_range(0, 19);
        slave_data[k] = 8'($urandom);
      end
      noise_mask = NS'($urandom);
      r_adr = 8'($urandom);
      r_dat = 8'($urandom);
      applyStimulus(1'($urandom_range(0, 1)), r_adr, r_dat, (t % 5 == 4) && (t < 39));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
